// File: rtl/spi_reg_bridge_if.sv
// Bus bundle between the SPI byte engine side and the register bridge.
// Carries the SPI-side byte/CS signals, the read-response handshake, the
// exported register file, the write-notification strobe and the error flag.
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 4
);
  logic                       spi_cs;        // raw chip select, active low, async
  logic [7:0]                 spi_rx_byte;   // slave data_out (sck domain)
  logic                       spi_rx_valid;  // slave data_out_valid (sck domain, level)
  logic [7:0]                 spi_tx_byte;   // to slave data_in
  logic                       spi_tx_valid;  // to slave data_in_valid, 1-cycle pulse
  logic [8*(2**ADDR_W)-1:0]   reg_q;         // flat register file, reg n at [8n+7:8n]
  logic                       wr_stb;        // 1-cycle pulse per completed write
  logic [ADDR_W-1:0]          wr_addr;       // address of the flagged write
  logic [7:0]                 wr_data;       // data of the flagged write
  logic                       err;           // sticky out-of-range flag

  modport slave (
    input  spi_cs, spi_rx_byte, spi_rx_valid,
    output spi_tx_byte, spi_tx_valid, reg_q, wr_stb, wr_addr, wr_data, err
  );

  modport master (
    output spi_cs, spi_rx_byte, spi_rx_valid,
    input  spi_tx_byte, spi_tx_valid, reg_q, wr_stb, wr_addr, wr_data, err
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI register bridge: decodes {rw,addr} command frames from the SPI slave byte
// stream, maintains a 2**ADDR_W byte register file and loads read responses.
// Ports: clk, rst (sync, active high), bus (spi_reg_bridge_if.slave: SPI bytes/CS in,
// tx byte/valid out, reg_q, wr_stb/wr_addr/wr_data, err).
module spi_reg_bridge #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_reg_bridge_if.slave    bus
);

  localparam int NBITS = 8 * (2**ADDR_W);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] RDONE = 3'd3;
  localparam logic [2:0] LOAD  = 3'd4;

  // Synchronizers; fill_q tracks when the cs chain holds only real pad samples.
  logic [SYNC_STAGES-1:0] cs_sync_q, rv_sync_q, fill_q;
  logic                   cs_prev_q, rv_prev_q;
  logic                   armed_q, armed_d;

  logic [2:0]        state_q, state_d;
  logic              rw_q, rw_d;
  logic              oor_q, oor_d;
  logic              have_cmd_q, have_cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NBITS-1:0]  regs_q, regs_d;
  logic              err_q, err_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;

  logic       cs_s, rv_s, byte_stb, cs_fall, cs_rise, cmd_oor;
  logic [7:0] load_val;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign rv_s     = rv_sync_q[SYNC_STAGES-1];
  assign byte_stb = rv_s & ~rv_prev_q;
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign cmd_oor  = (bus.spi_rx_byte[6:0] >> ADDR_W) != 7'd0;

  // A frame only starts once cs has been genuinely seen high after reset, so
  // the reset-forced high in the synchronizer cannot fake a cs_fall mid-frame.
  assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);

  always_comb begin
    load_val = 8'h00;
    if (have_cmd_q && rw_q) begin
      load_val = oor_q ? 8'hFF : regs_q[{addr_q, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    oor_d      = oor_q;
    have_cmd_d = have_cmd_q;
    addr_d     = addr_q;
    regs_d     = regs_q;
    err_d      = err_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d    = CMD;
          have_cmd_d = 1'b0;
          rw_d       = 1'b0;
          oor_d      = 1'b0;
        end
      end
      CMD: begin
        if (byte_stb) begin
          have_cmd_d = 1'b1;
          rw_d       = bus.spi_rx_byte[7];
          addr_d     = bus.spi_rx_byte[ADDR_W-1:0];
          oor_d      = cmd_oor;
          if (cmd_oor) err_d = 1'b1;
          state_d    = bus.spi_rx_byte[7] ? RDONE : WDATA;
        end
        // A byte arriving with cs_rise is decoded above, then the frame closes.
        if (cs_rise) state_d = LOAD;
      end
      WDATA: begin
        if (byte_stb && !oor_q) begin
          regs_d[{addr_q, 3'b000} +: 8] = bus.spi_rx_byte;
          wr_stb_d  = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus.spi_rx_byte;
          addr_d    = addr_q + 1'b1;  // wraps modulo 2**ADDR_W
        end
        if (cs_rise) state_d = LOAD;
      end
      RDONE: begin
        if (cs_rise) state_d = LOAD;
      end
      LOAD: begin
        tx_byte_d  = load_val;
        tx_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q  <= '1;
      rv_sync_q  <= '0;
      fill_q     <= '0;
      cs_prev_q  <= 1'b1;
      rv_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      oor_q      <= 1'b0;
      have_cmd_q <= 1'b0;
      addr_q     <= '0;
      regs_q     <= '0;
      err_q      <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs};
      rv_sync_q  <= {rv_sync_q[SYNC_STAGES-2:0], bus.spi_rx_valid};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q  <= cs_s;
      rv_prev_q  <= rv_s;
      armed_q    <= armed_d;
      state_q    <= state_d;
      rw_q       <= rw_d;
      oor_q      <= oor_d;
      have_cmd_q <= have_cmd_d;
      addr_q     <= addr_d;
      regs_q     <= regs_d;
      err_q      <= err_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign bus.spi_tx_byte  = tx_byte_q;
  assign bus.spi_tx_valid = tx_valid_q;
  assign bus.reg_q        = regs_q;
  assign bus.wr_stb       = wr_stb_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: drives SPI bytes/CS directly on the bus
// interface and compares register file, write strobes and tx responses
// against hand-computed values.
module tb_spi_reg_bridge;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  spi_reg_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Output monitor, sampled on the falling edge.
  int         wr_cnt = 0;
  int         tx_cnt = 0;
  logic [7:0] tx_last = 8'hEE;
  int         wr_addr_log[$];
  int         wr_data_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_stb) begin
        wr_cnt = wr_cnt + 1;
        wr_addr_log.push_back(int'(bus.wr_addr));
        wr_data_log.push_back(int'(bus.wr_data));
      end
      if (bus.spi_tx_valid) begin
        tx_cnt  = tx_cnt + 1;
        tx_last = bus.spi_tx_byte;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int n);
    return 32'(bus.reg_q[8*n +: 8]);
  endfunction

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    wr_cnt  = 0;
    tx_cnt  = 0;
    tx_last = 8'hEE;
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  task automatic send(input logic [7:0] b);
    bus.spi_rx_byte  = b;
    bus.spi_rx_valid = 1'b1;
    clk_n(6);
    bus.spi_rx_valid = 1'b0;
    clk_n(6);
  endtask

  task automatic cs_low();
    bus.spi_cs = 1'b0;
    clk_n(6);
  endtask

  task automatic cs_high();
    bus.spi_cs = 1'b1;
    clk_n(10);
  endtask

  logic [8*(2**ADDR_W)-1:0] snap;

  initial begin
    bus.spi_cs       = 1'b1;
    bus.spi_rx_byte  = 8'h00;
    bus.spi_rx_valid = 1'b0;
    rst = 1'b1;
    clk_n(3);
    rst = 1'b0;
    clk_n(1);

    // 1. Reset state, idle cs produces no response.
    check("rst_tx_byte",  32'(bus.spi_tx_byte), 0);
    check("rst_tx_valid", 32'(bus.spi_tx_valid), 0);
    check("rst_wr_stb",   32'(bus.wr_stb), 0);
    check("rst_wr_addr",  32'(bus.wr_addr), 0);
    check("rst_wr_data",  32'(bus.wr_data), 0);
    check("rst_err",      32'(bus.err), 0);
    check("rst_regs",     32'(|bus.reg_q), 0);
    clr_mon();
    clk_n(20);
    check("idle_no_tx", 32'(tx_cnt), 0);

    // 2. Write frame 03,5A,C3.
    clr_mon();
    cs_low(); send(8'h03); send(8'h5A); send(8'hC3); cs_high();
    check("wr_cnt",     32'(wr_cnt), 2);
    check("wr0_addr",   32'(wr_addr_log[0]), 3);
    check("wr0_data",   32'(wr_data_log[0]), 32'h5A);
    check("wr1_addr",   32'(wr_addr_log[1]), 4);
    check("wr1_data",   32'(wr_data_log[1]), 32'hC3);
    check("reg3",       rd(3), 32'h5A);
    check("reg4",       rd(4), 32'hC3);
    check("wr_tx_cnt",  32'(tx_cnt), 1);
    check("wr_tx_byte", 32'(tx_last), 32'h00);
    check("wr_addr_hold", 32'(bus.wr_addr), 4);
    check("wr_data_hold", 32'(bus.wr_data), 32'hC3);
    check("wr_err",     32'(bus.err), 0);

    // 3. Read reg3.
    clr_mon();
    cs_low(); send(8'h83); send(8'h12); cs_high();
    check("rd_tx_cnt",  32'(tx_cnt), 1);
    check("rd_tx_byte", 32'(tx_last), 32'h5A);
    check("rd_no_wr",   32'(wr_cnt), 0);
    check("rd_tx_hold", 32'(bus.spi_tx_byte), 32'h5A);

    // Empty frame loads 00.
    clr_mon();
    cs_low(); cs_high();
    check("empty_tx_cnt",  32'(tx_cnt), 1);
    check("empty_tx_byte", 32'(tx_last), 32'h00);

    // 4. Address wrap, then read back.
    clr_mon();
    cs_low(); send(8'h0F); send(8'h11); send(8'h22); cs_high();
    check("wrap_reg15", rd(15), 32'h11);
    check("wrap_reg0",  rd(0), 32'h22);
    check("wrap_addr0", 32'(wr_addr_log[0]), 15);
    check("wrap_addr1", 32'(wr_addr_log[1]), 0);
    clr_mon();
    cs_low(); send(8'h8F); cs_high();
    check("rd15_tx", 32'(tx_last), 32'h11);
    check("pre_oor_err", 32'(bus.err), 0);

    // Out-of-range read.
    clr_mon();
    cs_low(); send(8'hA0); cs_high();
    check("oor_rd_err",    32'(bus.err), 1);
    check("oor_rd_tx_cnt", 32'(tx_cnt), 1);
    check("oor_rd_tx",     32'(tx_last), 32'hFF);

    // 5. Out-of-range write.
    snap = bus.reg_q;
    clr_mon();
    cs_low(); send(8'h40); send(8'h77); cs_high();
    check("oor_wr_cnt",  32'(wr_cnt), 0);
    check("oor_wr_regs", 32'(bus.reg_q == snap), 1);
    check("oor_wr_err",  32'(bus.err), 1);
    check("oor_wr_tx",   32'(tx_last), 32'h00);

    // Command byte and cs rise land in the same cycle: read of reg4.
    clr_mon();
    cs_low();
    bus.spi_rx_byte  = 8'h84;
    bus.spi_rx_valid = 1'b1;
    bus.spi_cs       = 1'b1;
    clk_n(10);
    bus.spi_rx_valid = 1'b0;
    clk_n(4);
    check("simul_tx_cnt", 32'(tx_cnt), 1);
    check("simul_tx",     32'(tx_last), 32'hC3);

    // 6. Reset mid-frame after a write command, cs held low.
    clr_mon();
    cs_low(); send(8'h05);
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
    clk_n(1);
    check("mid_rst_err",  32'(bus.err), 0);
    check("mid_rst_regs", 32'(|bus.reg_q), 0);
    send(8'hAA); send(8'hBB); cs_high();
    check("mid_rst_wr_cnt", 32'(wr_cnt), 0);
    check("mid_rst_tx_cnt", 32'(tx_cnt), 0);
    check("mid_rst_reg5",   rd(5), 0);
    clr_mon();
    cs_low(); send(8'h05); send(8'h66); cs_high();
    check("post_rst_reg5",   rd(5), 32'h66);
    check("post_rst_wr_cnt", 32'(wr_cnt), 1);
    check("post_rst_tx_cnt", 32'(tx_cnt), 1);
    check("post_rst_tx",     32'(tx_last), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
